// File: rtl/msp430_pkg.sv
// Shared definitions for the instruction fetch path.
// Holds the reset vector location, the lowest valid ROM address, the fetch
// FSM state encoding and the layout of one prefetch queue entry.
package msp430_pkg;

  localparam logic [15:0] RESET_VECTOR = 16'hFFFE;
  localparam logic [15:0] ROM_BOUND_L  = 16'hC000;

  localparam int ENTRY_W = 33;

  typedef enum logic [0:0] {
    S_VEC = 1'b0,
    S_RUN = 1'b1
  } fetch_state_t;

  // One queue entry: address of the word, the word itself, and a flag set
  // when the address lies below the ROM window.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
    logic        oob;
  } fetch_entry_t;

  // Instruction words are 16-bit aligned; bit 0 of any target is dropped.
  function automatic logic [15:0] word_align(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch queue between the fetch FSM and the decoder.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   push, din     - write an entry; accepted when not full or when a pop
//                   happens on the same edge
//   pop           - drop the head entry; ignored when empty
//   flush         - empty the queue, overriding push and pop
//   dout          - head entry (contents undefined while empty)
//   full, empty   - occupancy flags
module fetch_fifo
  import msp430_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the empty flag gates every use of dout.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads the start PC from the reset vector, then
// streams sequential ROM words into a two-entry prefetch queue toward the
// decoder, with redirect (branch/jump) support.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   rom_addr / rom_data         - combinational ROM, data valid same cycle
//   redirect, redirect_pc       - branch/jump request and its target
//   ir_valid, ir_ready          - decoder handshake
//   ir_word, ir_pc, ir_oob      - head word, its address, below-ROM flag;
//                                 all zero while ir_valid is low
//   align_err                   - one-cycle pulse after an odd redirect
//
// state | meaning
// ------+------------------------------------------------------------
// S_VEC | drive RESET_VECTOR to the ROM, load fetch_pc from the word
// S_RUN | fetch sequentially from fetch_pc into the prefetch queue
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = msp430_pkg::RESET_VECTOR,
  parameter logic [15:0] ROM_BOUND_L  = msp430_pkg::ROM_BOUND_L
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_word,
  output logic [15:0] ir_pc,
  output logic        ir_oob,
  output logic        align_err
);

  import msp430_pkg::*;

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [15:0]  fetch_pc_q;
  logic [15:0]  fetch_pc_d;
  logic         align_err_q;
  logic         align_err_d;

  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [ENTRY_W-1:0] fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_VEC;
      fetch_pc_q  <= 16'h0000;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      align_err_q <= align_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    align_err_d = 1'b0;
    rom_addr    = RESET_VECTOR;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    case (state_q)
      S_VEC: begin
        rom_addr   = RESET_VECTOR;
        fetch_pc_d = word_align(rom_data);
        state_d    = S_RUN;
      end
      S_RUN: begin
        rom_addr = fetch_pc_q;
        if (redirect) begin
          // Flush wins over any handshake in the same cycle.
          flush       = 1'b1;
          fetch_pc_d  = word_align(redirect_pc);
          align_err_d = redirect_pc[0];
        end else begin
          pop  = !empty && ir_ready;
          push = !full || pop;
          if (push) begin
            fetch_pc_d = fetch_pc_q + 16'd2;
          end
        end
      end
      default: begin
        state_d = S_VEC;
      end
    endcase
  end

  assign push_entry.pc   = fetch_pc_q;
  assign push_entry.word = rom_data;
  assign push_entry.oob  = (fetch_pc_q < ROM_BOUND_L);

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign head      = fetch_entry_t'(fifo_dout);
  assign ir_valid  = !empty;
  assign ir_word   = empty ? 16'h0000 : head.word;
  assign ir_pc     = empty ? 16'h0000 : head.pc;
  assign ir_oob    = empty ? 1'b0     : head.oob;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word;
  logic [15:0] ir_pc;
  logic        ir_oob;
  logic        align_err;

  always #5 clk = ~clk;

  // ROM image: the reset vector points at C000, everything else is a
  // scrambled function of the address.
  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    if (a == 16'hFFFE) return 16'hC000;
    return (a ^ 16'hA5A5) + 16'h0101;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_word     (ir_word),
    .ir_pc       (ir_pc),
    .ir_oob      (ir_oob),
    .align_err   (align_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of fetched words plus the next address.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
    logic        oob;
  } ent_t;

  ent_t        mq[$];
  bit          m_on  = 1'b0;
  bit          m_run = 1'b0;
  logic [15:0] m_pc  = 16'h0000;
  bit          m_align = 1'b0;
  bit          m_pop;
  ent_t        m_new;
  ent_t        m_head;

  always @(posedge clk) begin
    if (rst) begin
      m_on    = 1'b1;
      m_run   = 1'b0;
      m_pc    = 16'h0000;
      m_align = 1'b0;
      mq.delete();
    end else if (m_on) begin
      if (!m_run) begin
        m_pc    = rom_fn(16'hFFFE) & 16'hFFFE;
        m_run   = 1'b1;
        m_align = 1'b0;
      end else if (redirect) begin
        mq.delete();
        m_pc    = redirect_pc & 16'hFFFE;
        m_align = redirect_pc[0];
      end else begin
        m_align = 1'b0;
        m_pop   = (mq.size() > 0) && ir_ready;
        if (m_pop) void'(mq.pop_front());
        if (mq.size() < 2) begin
          m_new.pc   = m_pc;
          m_new.word = rom_fn(m_pc);
          m_new.oob  = (m_pc < 16'hC000);
          mq.push_back(m_new);
          m_pc = m_pc + 16'd2;
        end
      end
    end
    #1;
    if (m_on) begin
      check("m_rom_addr", rom_addr, m_run ? m_pc : 16'hFFFE);
      check("m_align_err", 16'(align_err), 16'(m_align));
      check("m_ir_valid", 16'(ir_valid), 16'(mq.size() != 0));
      if (mq.size() != 0) begin
        m_head = mq[0];
        check("m_ir_pc", ir_pc, m_head.pc);
        check("m_ir_word", ir_word, m_head.word);
        check("m_ir_oob", 16'(ir_oob), 16'(m_head.oob));
      end else begin
        check("m_ir_pc_idle", ir_pc, 16'h0000);
        check("m_ir_word_idle", ir_word, 16'h0000);
        check("m_ir_oob_idle", 16'(ir_oob), 16'h0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_pc;
    int          sel;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ir_ready    = 1'b0;
    repeat (3) tick();
    check("rst_valid", 16'(ir_valid), 16'h0000);
    check("rst_align", 16'(align_err), 16'h0000);

    // Reset vector fetch
    rst = 1'b0;
    check("vec_rom_addr", rom_addr, 16'hFFFE);
    tick();
    check("run_rom_addr", rom_addr, 16'hC000);
    check("run_valid0", 16'(ir_valid), 16'h0000);
    tick();
    check("first_valid", 16'(ir_valid), 16'h0001);
    check("first_pc", ir_pc, 16'hC000);
    check("first_word", ir_word, 16'h66A6);

    // Backpressure: queue fills, fetch_pc stalls at C004
    repeat (4) tick();
    check("bp_pc", ir_pc, 16'hC000);
    check("bp_word", ir_word, 16'h66A6);
    check("bp_stall_addr", rom_addr, 16'hC004);

    // Streaming
    ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_pc = 16'hC002 + 16'(2 * k);
      check("stream_pc", ir_pc, exp_pc);
    end

    // Odd redirect
    redirect    = 1'b1;
    redirect_pc = 16'hC101;
    tick();
    redirect = 1'b0;
    check("redir_align", 16'(align_err), 16'h0001);
    check("redir_bubble", 16'(ir_valid), 16'h0000);
    tick();
    check("redir_align_off", 16'(align_err), 16'h0000);
    check("redir_valid", 16'(ir_valid), 16'h0001);
    check("redir_pc", ir_pc, 16'hC100);
    check("redir_word", ir_word, 16'h65A6);

    // Wrap past FFFE into the out-of-ROM region
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    check("wrap_align", 16'(align_err), 16'h0000);
    tick();
    check("wrap_pc0", ir_pc, 16'hFFFC);
    check("wrap_word0", ir_word, 16'h5B5A);
    tick();
    check("wrap_pc1", ir_pc, 16'hFFFE);
    tick();
    check("wrap_pc2", ir_pc, 16'h0000);
    check("wrap_oob", 16'(ir_oob), 16'h0001);
    check("wrap_word2", ir_word, 16'hA6A6);

    // Reset with a full queue
    ir_ready = 1'b0;
    repeat (3) tick();
    check("full_valid", 16'(ir_valid), 16'h0001);
    rst      = 1'b1;
    redirect = 1'b1;
    ir_ready = 1'b1;
    tick();
    rst      = 1'b0;
    redirect = 1'b0;
    check("midrst_valid", 16'(ir_valid), 16'h0000);
    check("midrst_rom_addr", rom_addr, 16'hFFFE);
    tick();
    tick();
    check("midrst_refetch_pc", ir_pc, 16'hC000);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      ir_ready = ($urandom_range(0, 3) != 0);
      sel      = int'($urandom_range(0, 2));
      if (sel == 0)      redirect_pc = 16'($urandom);
      else if (sel == 1) redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
      else               redirect_pc = 16'hBFF0 + 16'($urandom_range(0, 31));
      tick();
    end
    rst      = 1'b0;
    redirect = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_VECTOR, default 16'hFFFE, meaning the ROM word address holding the start PC.
REQ-002 The module SHALL have parameter ROM_BOUND_L, default 16'hC000, meaning the lowest valid ROM byte address.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, meaning the synchronous active-high reset.
REQ-005 The module SHALL have port rom_addr, output, 16 bits, meaning the byte address driven to the combinational ROM.
REQ-006 The module SHALL have port rom_data, input, 16 bits, meaning the little-endian word returned by the ROM for rom_addr in the same cycle.
REQ-007 The module SHALL have ports redirect (input, 1) and redirect_pc (input, 16), meaning a branch or jump request with its target.
REQ-008 The module SHALL have ports ir_valid (output, 1), ir_ready (input, 1), ir_word (output, 16), ir_pc (output, 16) and ir_oob (output, 1), meaning the decoder-side word, its address and an out-of-ROM flag.
REQ-009 The module SHALL have port align_err, output, 1 bit, meaning a one-cycle pulse on an odd redirect target.

Function
REQ-010 The FSM SHALL have states S_VEC and S_RUN.
REQ-011 In S_VEC, rom_addr SHALL equal RESET_VECTOR; at the next edge fetch_pc SHALL load {rom_data[15:1],1'b0} and the state SHALL move to S_RUN.
REQ-012 In S_RUN, rom_addr SHALL equal fetch_pc.
REQ-013 In S_RUN, each edge with queue space or a same-cycle pop SHALL push {fetch_pc, rom_data, fetch_pc<ROM_BOUND_L} and advance fetch_pc by 2.
REQ-014 fetch_pc SHALL wrap modulo 2^16, so 16'hFFFE is followed by 16'h0000.
REQ-015 The prefetch queue SHALL hold 2 entries; when it is full and there is no pop, it SHALL neither push nor advance fetch_pc.
REQ-016 ir_valid SHALL be 1 when the queue is non-empty; ir_word, ir_pc and ir_oob SHALL present the head entry.
REQ-017 The head SHALL pop on an edge where ir_valid and ir_ready are both 1.
REQ-018 A push and a pop in the same cycle SHALL both occur and leave the occupancy unchanged.
REQ-019 While ir_valid=1 and ir_ready=0, ir_word, ir_pc and ir_oob SHALL hold stable.
REQ-020 On redirect=1 in S_RUN, the next edge SHALL empty the queue, discard any push and pop that cycle, and load fetch_pc with {redirect_pc[15:1],1'b0}.
REQ-021 Redirect timing: ir_valid SHALL be 0 in the cycle after a redirect edge, and the first target word SHALL be valid one cycle later.
REQ-022 A redirect with redirect_pc[0]=1 SHALL pulse align_err for exactly the one cycle after that edge.
REQ-023 redirect SHALL be ignored in S_VEC.
REQ-024 When ir_valid=0, ir_word, ir_pc and ir_oob SHALL be 0.

Reset
REQ-025 rst=1 at an edge SHALL set: state S_VEC, fetch_pc 0, queue empty, ir_valid 0, ir_word 0, ir_pc 0, ir_oob 0, align_err 0.
REQ-026 rst SHALL override redirect and all handshakes, including mid-operation with a full queue.
REQ-027 The vector fetch SHALL begin in the first cycle with rst=0.

Structure
REQ-028 RESET_VECTOR, ROM_BOUND_L, the state encoding and the queue-entry width (33 bits) SHALL live in the shared package msp430_pkg.
REQ-029 The 2-entry queue SHALL be the sub-module fetch_fifo, with ports push, pop, flush, din, dout, full and empty.
REQ-030 The fetch_unit top SHALL hold the FSM and fetch_pc.

Verification
REQ-031 Reset vector: ROM[FFFE]=16'hC000 -> in the first cycle after rst, rom_addr=FFFE; ir_valid=1 two edges later with ir_pc=C000 and ir_word=ROM[C000].
REQ-032 Backpressure: ir_ready=0 for 5 cycles -> queue fills to 2 entries and fetch_pc stalls at C004; ir_word stays ROM[C000].
REQ-033 Streaming: ir_ready=1 continuously -> one word per cycle in the order C000, C002, C004, ...
REQ-034 Redirect: redirect=1, redirect_pc=16'hC101 -> align_err pulses and ir_valid=0 for one cycle; the next valid word has ir_pc=C100.
REQ-035 Wrap and oob: redirect to FFFC -> ir_pc sequence FFFC, FFFE, 0000; the 0000 entry has ir_oob=1.
REQ-036 Reset mid-operation: rst with a full queue -> ir_valid=0 next cycle, then S_VEC refetch from FFFE.
